// File: rtl/pwm_pkg.sv
// Shared constants and dead-time FSM state encoding for the PWM gate driver.
package pwm_pkg;

   localparam int unsigned DefaultPeriod   = 1000;
   localparam int unsigned DefaultDeadTime = 4;

   typedef enum logic [2:0] {
      StIdle,
      StLo,
      StDtLh,
      StHi,
      StDtHl
   } dt_state_e;

endpackage

// File: rtl/deadtime_fsm.sv
// Dead-time sequencer: turns the raw comparator output into complementary
// high/low gate drives separated by DEAD_TIME cycles of both-off.
module deadtime_fsm
   import pwm_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 10,
   parameter int unsigned DEAD_TIME = DefaultDeadTime
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   input  logic enable,
   output logic pwm_hi,
   output logic pwm_lo
);

   localparam logic [CNT_WIDTH-1:0] DtLoad = CNT_WIDTH'(DEAD_TIME - 1);
   localparam logic [CNT_WIDTH-1:0] DtOne  = CNT_WIDTH'(1);

   dt_state_e              state_q, state_d;
   logic [CNT_WIDTH-1:0]   dtcnt_q, dtcnt_d;

   always_comb begin
      state_d = state_q;
      dtcnt_d = dtcnt_q;
      if (!enable) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               state_d = StDtHl;
               dtcnt_d = DtLoad;
            end
            StLo: begin
               if (raw) begin
                  state_d = StDtLh;
                  dtcnt_d = DtLoad;
               end
            end
            StHi: begin
               if (!raw) begin
                  state_d = StDtHl;
                  dtcnt_d = DtLoad;
               end
            end
            // Both dead states resolve to whichever side raw requests at expiry,
            // so a raw pulse shorter than the dead time falls back silently.
            StDtLh, StDtHl: begin
               if (dtcnt_q == '0) begin
                  state_d = raw ? StHi : StLo;
               end else begin
                  dtcnt_d = dtcnt_q - DtOne;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         dtcnt_q <= '0;
         pwm_hi  <= 1'b0;
         pwm_lo  <= 1'b0;
      end else begin
         state_q <= state_d;
         dtcnt_q <= dtcnt_d;
         pwm_hi  <= (state_d == StHi);
         pwm_lo  <= (state_d == StLo);
      end
   end

endmodule

// File: rtl/pwm_deadtime_driver.sv
// PWM generator with clamped, double-buffered duty input and dead-time
// protected complementary gate outputs.
module pwm_deadtime_driver
   import pwm_pkg::*;
#(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned CNT_WIDTH = 10,
   parameter int unsigned PERIOD    = DefaultPeriod,
   parameter int unsigned DEAD_TIME = DefaultDeadTime
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [WIDTH-1:0] ctrl_in,
   input  logic                    ctrl_valid,
   output logic                    ctrl_ready,
   input  logic                    enable,
   output logic                    pwm_hi,
   output logic                    pwm_lo,
   output logic [CNT_WIDTH-1:0]    duty_out,
   output logic                    period_start,
   output logic                    sat_flag
);

   localparam logic [CNT_WIDTH-1:0]    CntLast = CNT_WIDTH'(PERIOD - 1);
   localparam logic [CNT_WIDTH-1:0]    CntOne  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]    DutyMax = CNT_WIDTH'(PERIOD);
   localparam logic signed [WIDTH-1:0] LimitHi = WIDTH'(PERIOD);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] shadow_q, shadow_d;
   logic [CNT_WIDTH-1:0] duty_q, duty_d;
   logic                 pending_q, pending_d;
   logic                 sat_q, sat_d;
   logic                 accept, wrap, raw;
   logic [CNT_WIDTH-1:0] clamped;
   logic                 clamp_hit;

   assign accept = ctrl_valid && ctrl_ready;
   assign wrap   = enable && (cnt_q == CntLast);
   assign raw    = (cnt_q < duty_q);

   always_comb begin
      clamped   = ctrl_in[CNT_WIDTH-1:0];
      clamp_hit = 1'b0;
      if (ctrl_in[WIDTH-1]) begin
         clamped   = '0;
         clamp_hit = 1'b1;
      end else if (ctrl_in > LimitHi) begin
         clamped   = DutyMax;
         clamp_hit = 1'b1;
      end
   end

   always_comb begin
      cnt_d     = cnt_q;
      shadow_d  = shadow_q;
      duty_d    = duty_q;
      pending_d = pending_q;
      sat_d     = sat_q;
      if (!enable) begin
         cnt_d = '0;
      end else if (wrap) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CntOne;
      end
      if (wrap && pending_q) begin
         duty_d    = shadow_q;
         pending_d = 1'b0;
      end
      // Accept only happens with pending clear, so a same-cycle wrap cannot
      // pick up the new value; it waits for the following wrap.
      if (accept) begin
         shadow_d  = clamped;
         pending_d = 1'b1;
         sat_d     = clamp_hit;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q     <= '0;
         shadow_q  <= '0;
         duty_q    <= '0;
         pending_q <= 1'b0;
         sat_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         shadow_q  <= shadow_d;
         duty_q    <= duty_d;
         pending_q <= pending_d;
         sat_q     <= sat_d;
      end
   end

   assign ctrl_ready   = reset && !pending_q;
   assign period_start = reset && enable && (cnt_q == '0);
   assign duty_out     = duty_q;
   assign sat_flag     = sat_q;

   deadtime_fsm #(
      .CNT_WIDTH (CNT_WIDTH),
      .DEAD_TIME (DEAD_TIME)
   ) u_deadtime_fsm (
      .clk    (clk),
      .reset  (reset),
      .raw    (raw),
      .enable (enable),
      .pwm_hi (pwm_hi),
      .pwm_lo (pwm_lo)
   );

endmodule

// File: tb/tb_pwm_deadtime_driver.sv
// Bench for pwm_deadtime_driver: cycle model of period/duty/dead-time rules
// checked every cycle, plus directed scenarios with literal expectations.
module tb_pwm_deadtime_driver;

   localparam int P  = 10;
   localparam int DT = 2;

   logic              clk;
   logic              reset;
   logic signed [15:0] ctrl_in;
   logic              ctrl_valid;
   logic              ctrl_ready;
   logic              enable;
   logic              pwm_hi;
   logic              pwm_lo;
   logic [9:0]        duty_out;
   logic              period_start;
   logic              sat_flag;

   pwm_deadtime_driver #(
      .WIDTH     (16),
      .CNT_WIDTH (10),
      .PERIOD    (P),
      .DEAD_TIME (DT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ctrl_in      (ctrl_in),
      .ctrl_valid   (ctrl_valid),
      .ctrl_ready   (ctrl_ready),
      .enable       (enable),
      .pwm_hi       (pwm_hi),
      .pwm_lo       (pwm_lo),
      .duty_out     (duty_out),
      .period_start (period_start),
      .sat_flag     (sat_flag)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: gate side 0=none, 1=low, 2=high; m_gap = dead cycles remaining.
   int  m_cnt, m_duty, m_shadow, m_side, m_gap;
   bit  m_pend, m_sat, m_idle, m_live;
   logic m_raw, m_wrap, m_acc;

   assign m_raw  = (m_cnt < m_duty);
   assign m_wrap = enable && (m_cnt == P - 1);
   assign m_acc  = ctrl_valid && !m_pend;

   function automatic int clampv(input int v);
      if (v < 0) return 0;
      if (v > P) return P;
      return v;
   endfunction

   always @(posedge clk) begin
      if (!reset) begin
         m_cnt <= 0; m_duty <= 0; m_shadow <= 0; m_pend <= 0; m_sat <= 0;
         m_idle <= 1; m_side <= 0; m_gap <= 0; m_live <= 1;
      end else begin
         if (!enable) begin
            m_idle <= 1; m_side <= 0; m_gap <= 0;
         end else if (m_idle) begin
            m_idle <= 0; m_side <= 0; m_gap <= DT;
         end else if (m_gap == 1) begin
            m_side <= m_raw ? 2 : 1; m_gap <= 0;
         end else if (m_gap > 1) begin
            m_gap <= m_gap - 1;
         end else if ((m_side == 2) != m_raw) begin
            m_side <= 0; m_gap <= DT;
         end
         if (m_wrap && m_pend) begin
            m_duty <= m_shadow; m_pend <= 0;
         end
         if (m_acc) begin
            m_shadow <= clampv(int'(ctrl_in));
            m_pend   <= 1;
            m_sat    <= (int'(ctrl_in) < 0) || (int'(ctrl_in) > P);
         end
         m_cnt <= (!enable || m_wrap) ? 0 : m_cnt + 1;
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         assert (!(pwm_hi && pwm_lo)) else $error("FAIL overlap: both gates high");
         chk("no_overlap", int'(pwm_hi && pwm_lo), 0);
         chk("pwm_hi", int'(pwm_hi), int'(m_side == 2));
         chk("pwm_lo", int'(pwm_lo), int'(m_side == 1));
         chk("duty_out", int'(duty_out), m_duty);
         chk("sat_flag", int'(sat_flag), int'(m_sat));
         chk("ctrl_ready", int'(ctrl_ready), int'(reset && !m_pend));
         chk("period_start", int'(period_start), int'(reset && enable && m_cnt == 0));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int v);
      int k = 0;
      ctrl_in    = 16'(v);
      ctrl_valid = 1'b1;
      while (!ctrl_ready && k < 40) begin
         tick();
         k++;
      end
      if (k >= 40) chk("send_timeout", 0, 1);
      tick();
      ctrl_valid = 1'b0;
   endtask

   task automatic wait_ps();
      int k = 0;
      do begin
         tick();
         k++;
      end while (!period_start && k < 40);
      if (!period_start) chk("ps_timeout", 0, 1);
   endtask

   task automatic wait_hi();
      int k = 0;
      while (!pwm_hi && k < 40) begin
         tick();
         k++;
      end
      if (!pwm_hi) chk("hi_timeout", 0, 1);
   endtask

   task automatic count_win(output int h, output int l);
      h = 0;
      l = 0;
      repeat (P) begin
         @(negedge clk);
         h += int'(pwm_hi);
         l += int'(pwm_lo);
      end
   endtask

   int h, l;

   initial begin
      reset      = 1'b0;
      enable     = 1'b0;
      ctrl_valid = 1'b0;
      ctrl_in    = '0;
      repeat (3) tick();
      chk("rst_hi", int'(pwm_hi), 0);
      chk("rst_lo", int'(pwm_lo), 0);
      chk("rst_duty", int'(duty_out), 0);
      chk("rst_sat", int'(sat_flag), 0);
      chk("rst_ready", int'(ctrl_ready), 0);
      chk("rst_ps", int'(period_start), 0);
      reset = 1'b1;
      tick();
      chk("ready_after_rst", int'(ctrl_ready), 1);

      // Duty 4 accepted mid-period
      enable = 1'b1;
      repeat (5) tick();
      send(4);
      wait_ps(); wait_ps();
      count_win(h, l);
      chk("d4_hi_cycles", h, 2);
      chk("d4_lo_cycles", l, 4);
      chk("d4_duty", int'(duty_out), 4);
      chk("d4_sat", int'(sat_flag), 0);

      // Negative clamps to 0
      send(-5);
      chk("neg_sat", int'(sat_flag), 1);
      wait_ps(); wait_ps();
      count_win(h, l);
      chk("neg_hi_cycles", h, 0);
      chk("neg_lo_cycles", l, 10);
      chk("neg_duty", int'(duty_out), 0);

      // Over-range clamps to PERIOD
      send(50);
      wait_ps(); wait_ps();
      count_win(h, l);
      chk("big_hi_cycles", h, 10);
      chk("big_duty", int'(duty_out), 10);
      chk("big_sat", int'(sat_flag), 1);

      // Back-to-back 3 then 7
      tick();
      send(3);
      ctrl_in    = 16'sd7;
      ctrl_valid = 1'b1;
      chk("b2b_busy", int'(ctrl_ready), 0);
      begin
         int k = 0;
         while (!ctrl_ready && k < 40) begin
            tick();
            k++;
         end
         if (k >= 40) chk("b2b_timeout", 0, 1);
      end
      chk("b2b_ready_at_wrap", int'(period_start), 1);
      chk("b2b_duty3", int'(duty_out), 3);
      tick();
      ctrl_valid = 1'b0;
      chk("b2b_sat", int'(sat_flag), 0);
      wait_ps();
      chk("b2b_duty7", int'(duty_out), 7);

      // Pulse shorter than dead time
      send(1);
      wait_ps(); wait_ps();
      count_win(h, l);
      chk("short_hi_cycles", h, 0);
      chk("short_lo_cycles", l, 8);

      // Stop mid-HI; accepts continue but no load while stopped
      send(6);
      wait_ps(); wait_ps();
      wait_hi();
      enable = 1'b0;
      tick();
      chk("stop_hi", int'(pwm_hi), 0);
      chk("stop_lo", int'(pwm_lo), 0);
      chk("stop_ps", int'(period_start), 0);
      send(2);
      chk("stop_ready", int'(ctrl_ready), 0);
      repeat (15) tick();
      chk("stop_duty_held", int'(duty_out), 6);
      enable = 1'b1;
      wait_ps();
      chk("restart_duty", int'(duty_out), 2);

      // Reset mid-HI
      send(50);
      wait_ps(); wait_ps();
      wait_hi();
      reset = 1'b0;
      tick();
      chk("mrst_hi", int'(pwm_hi), 0);
      chk("mrst_lo", int'(pwm_lo), 0);
      chk("mrst_duty", int'(duty_out), 0);
      chk("mrst_sat", int'(sat_flag), 0);
      chk("mrst_ready", int'(ctrl_ready), 0);
      reset = 1'b1;
      tick();
      chk("mrst_ready_release", int'(ctrl_ready), 1);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pwm_deadtime_driver.md
PWM_DEADTIME_DRIVER -- requirements
Module: pwm_deadtime_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bit width of the signed control input.
REQ-002 SHALL have parameter CNT_WIDTH, default 10: bit width of the period counter and duty value.
REQ-003 SHALL have parameter PERIOD, default 1000: PWM period in clk cycles, 2..2^CNT_WIDTH-1.
REQ-004 SHALL have parameter DEAD_TIME, default 4: cycles during which both outputs are low at each transition, 1..PERIOD/2.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port ctrl_in, input, WIDTH signed: controller output from pid_controller.
REQ-008 SHALL have port ctrl_valid, input, 1: ctrl_in is valid.
REQ-009 SHALL have port ctrl_ready, output, 1: the shadow register can accept a value.
REQ-010 SHALL have port enable, input, 1: run/stop control.
REQ-011 SHALL have port pwm_hi, output, 1: high-side gate drive.
REQ-012 SHALL have port pwm_lo, output, 1: low-side gate drive.
REQ-013 SHALL have port duty_out, output, CNT_WIDTH: the active duty value.
REQ-014 SHALL have port period_start, output, 1: single-cycle pulse at cnt==0.
REQ-015 SHALL have port sat_flag, output, 1: the last accepted value was clamped.

Function
REQ-016 SHALL run counter cnt 0..PERIOD-1 and wrap to 0 while enable=1; cnt SHALL hold at 0 while enable=0.
REQ-017 SHALL assert period_start for exactly one cycle when cnt==0 and enable=1.
REQ-018 SHALL accept a value on ctrl_valid&&ctrl_ready; ctrl_ready SHALL equal !pending; ctrl_valid without ctrl_ready SHALL be ignored, with no loss of the held value.
REQ-019 SHALL clamp the accepted value: ctrl_in<0 gives 0, ctrl_in>PERIOD gives PERIOD, otherwise ctrl_in[CNT_WIDTH-1:0]; it SHALL store the result in the shadow register and set pending=1.
REQ-020 SHALL set sat_flag on an accept that clamps and clear it on an accept that does not; sat_flag SHALL hold between accepts.
REQ-021 SHALL, in the cycle cnt==PERIOD-1 with pending=1, load the shadow into the active duty and clear pending; duty_out SHALL update from the next cycle.
REQ-022 SHALL, when an accept and a wrap occur in the same cycle, apply the new value at the following wrap and not the current one.
REQ-023 SHALL leave active duty and the shadow unchanged by enable=0; accepts SHALL continue, but wrap loads SHALL not occur while stopped.
REQ-024 SHALL compute raw = (cnt < duty): duty=0 gives constant low, duty=PERIOD gives constant high.
REQ-025 SHALL run a dead-time FSM with states IDLE, LO, DT_LH, HI, DT_HL; pwm_hi=1 only in HI, pwm_lo=1 only in LO; both outputs SHALL be registered.
REQ-026 SHALL make these FSM transitions:
- LO&raw goes to DT_LH.
- HI&!raw goes to DT_HL.
- DT_LH and DT_HL each load dtcnt=DEAD_TIME-1 on entry.
- DT_LH at dtcnt==0 goes to HI if raw, else to LO.
- DT_HL at dtcnt==0 goes to LO if !raw, else to HI.
- IDLE&enable goes to DT_HL.
- Any state with enable=0 goes to IDLE.
REQ-027 SHALL never assert pwm_hi and pwm_lo in the same cycle, and SHALL hold both low for at least DEAD_TIME cycles between any deassertion of one and assertion of the other.
REQ-028 SHALL suppress the pulse when a raw pulse is shorter than DEAD_TIME: the FSM returns to the prior side and emits no glitch.

Reset
REQ-029 SHALL, with reset=0 at a clock edge, clear cnt, dtcnt, shadow, pending, duty and sat_flag, and set FSM=IDLE.
REQ-030 SHALL drive pwm_hi=0, pwm_lo=0, period_start=0, duty_out=0, sat_flag=0 and ctrl_ready=0 while reset=0; ctrl_ready SHALL be 1 in the first cycle after release.
REQ-031 SHALL, on reset mid-period, force both gate outputs low at that edge, with no dead-time sequencing.

Structure
REQ-032 SHALL place the FSM state encoding and the default PERIOD/DEAD_TIME constants in shared package pwm_pkg.
REQ-033 SHALL implement the dead-time FSM as sub-module deadtime_fsm (inputs: raw, enable; outputs: pwm_hi, pwm_lo).

Verification
(All scenarios use PERIOD=10, DEAD_TIME=2.)
REQ-034 SHALL cover ctrl_in=4 accepted mid-period: from the next wrap, each period gives pwm_hi high 2 cycles, pwm_lo high 4 cycles, and 2+2 dead cycles.
REQ-035 SHALL cover ctrl_in=-5: duty_out=0 and sat_flag=1; pwm_hi never asserts and pwm_lo is continuous.
REQ-036 SHALL cover ctrl_in=50: duty_out=10 and sat_flag=1; pwm_hi is continuous after dead time.
REQ-037 SHALL cover back-to-back valid values 3 then 7: the first is accepted, ctrl_ready=0 until the wrap, 7 is accepted the cycle after the wrap, and duty becomes 7 one period later.
REQ-038 SHALL cover ctrl_in=1 (pulse shorter than dead time): pwm_hi never asserts and pwm_lo never overlaps pwm_hi.
REQ-039 SHALL cover reset=0 and, separately, enable=0 mid-HI: outputs are low from the next edge, with no simultaneous-high cycle ever observed (assertion).
